// File: rtl/ccg_response_analyzer.sv
// Exhaustive stimulus generator and MISR response compactor for small combinational benchmark circuits.
// Walks x through every pattern, folds f into a signature and compares it against a golden value.
module ccg_response_analyzer #(
    parameter int                N_IN   = 5,
    parameter int                N_OUT  = 19,
    parameter logic [N_OUT-1:0]  POLY   = 19'h00027,
    parameter logic [N_OUT-1:0]  SEED   = 19'h00000,
    parameter int                SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  x,
    input  logic [N_OUT-1:0] f,
    input  logic [N_OUT-1:0] expected,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic             sig_valid,
    output logic             match
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    // With no settle time each pattern is a single CAPTURE cycle.
    localparam logic [1:0]      ST_PATTERN = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
    localparam logic [3:0]      WAIT_LAST  = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST     = '1;

    logic [1:0]       state_reg, state_next;
    logic [3:0]       wait_reg, wait_next;
    logic [N_IN-1:0]  x_reg, x_next;
    logic [N_OUT-1:0] sig_reg, sig_next;
    logic             done_reg, done_next;
    logic             valid_reg, valid_next;
    logic [N_OUT-1:0] misr_next;

    // Shift left, fold the MSB back through the taps, and absorb the response.
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_misr
        if (gi == 0) begin : g_lsb
            assign misr_next[gi] = (sig_reg[N_OUT-1] & POLY[gi]) ^ f[gi];
        end else begin : g_upper
            assign misr_next[gi] = sig_reg[gi-1] ^ (sig_reg[N_OUT-1] & POLY[gi]) ^ f[gi];
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        x_next     = x_reg;
        sig_next   = sig_reg;
        done_next  = 1'b0;
        valid_next = valid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_PATTERN;
                    wait_next  = 4'd0;
                    x_next     = '0;
                    sig_next   = SEED;
                    valid_next = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (wait_reg == WAIT_LAST) begin
                    wait_next  = 4'd0;
                    state_next = ST_CAPTURE;
                end else begin
                    wait_next = wait_reg + 4'd1;
                end
            end
            ST_CAPTURE: begin
                sig_next = misr_next;
                if (x_reg == X_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    valid_next = 1'b1;
                end else begin
                    x_next     = x_reg + 1'b1;
                    state_next = ST_PATTERN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            wait_reg  <= 4'd0;
            x_reg     <= '0;
            sig_reg   <= SEED;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            x_reg     <= x_next;
            sig_reg   <= sig_next;
            done_reg  <= done_next;
            valid_reg <= valid_next;
        end
    end

    assign x         = x_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign signature = sig_reg;
    assign sig_valid = valid_reg;
    assign match     = valid_reg && (sig_reg == expected);

endmodule

// File: tb/tb_ccg_response_analyzer.sv
// Bench for ccg_response_analyzer: one instance with SETTLE=0 and one with SETTLE=2, checked every
// cycle against a cycle-index model plus literal expectations for the directed scenarios.
module tb_ccg_response_analyzer;

    localparam logic [18:0] POLY_C = 19'h00027;
    localparam logic [18:0] SEED_C = 19'h00000;

    logic        clk;
    logic        rst;
    logic        start_w [2];
    logic [4:0]  x_w     [2];
    logic [18:0] f_w     [2];
    logic [18:0] exp_w   [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [18:0] sig_w   [2];
    logic        valid_w [2];
    logic        match_w [2];
    int          mode    [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: m_k is the 1-based cycle index inside the current run.
    logic        m_active [2];
    int          m_k      [2];
    logic [18:0] m_sig    [2];
    logic        m_valid  [2];
    logic        m_done   [2];

    ccg_response_analyzer #(.N_IN(5), .N_OUT(19), .POLY(POLY_C), .SEED(SEED_C), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .x(x_w[0]), .f(f_w[0]), .expected(exp_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .signature(sig_w[0]), .sig_valid(valid_w[0]),
        .match(match_w[0])
    );

    ccg_response_analyzer #(.N_IN(5), .N_OUT(19), .POLY(POLY_C), .SEED(SEED_C), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_w[1]), .x(x_w[1]), .f(f_w[1]), .expected(exp_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .signature(sig_w[1]), .sig_valid(valid_w[1]),
        .match(match_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Circuit-under-test responses. Mode 3 stands in for a generated netlist; mode 4 flips f5 at x==7.
    function automatic logic [18:0] resp(input int m, input logic [4:0] xv);
        logic [18:0] net;
        logic [4:0]  a;
        logic [4:0]  b;
        a   = 5'(xv * 3);
        b   = 5'(xv + 5'd3);
        net = {a, b, xv[4] ^ xv[0], ^xv, xv[2] | xv[3], xv[0] & xv[1], xv ^ 5'h15};
        case (m)
            1:       return (xv == 5'd31) ? 19'h00001 : 19'h00000;
            2:       return (xv == 5'd30) ? 19'h00001 : 19'h00000;
            3:       return net;
            4:       return net ^ ((xv == 5'd7) ? 19'h00010 : 19'h00000);
            default: return 19'h00000;
        endcase
    endfunction

    function automatic logic [18:0] misr_step(input logic [18:0] s, input logic [18:0] r);
        return 19'(s << 1) ^ (s[18] ? POLY_C : 19'h0) ^ r;
    endfunction

    function automatic logic [18:0] misr_run(input int m);
        logic [18:0] s;
        s = SEED_C;
        for (int v = 0; v < 32; v++) s = misr_step(s, resp(m, 5'(v)));
        return s;
    endfunction

    function automatic int period_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign f_w[0] = resp(mode[0], x_w[0]);
    assign f_w[1] = resp(mode[1], x_w[1]);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_k[i]      <= 0;
                m_sig[i]    <= SEED_C;
                m_valid[i]  <= 1'b0;
                m_done[i]   <= 1'b0;
            end else if (!m_active[i]) begin
                m_done[i] <= 1'b0;
                if (start_w[i]) begin
                    m_active[i] <= 1'b1;
                    m_k[i]      <= 1;
                    m_sig[i]    <= SEED_C;
                    m_valid[i]  <= 1'b0;
                end
            end else begin
                m_done[i] <= 1'b0;
                if (m_k[i] % period_of(i) == 0)
                    m_sig[i] <= misr_step(m_sig[i], resp(mode[i], 5'((m_k[i] - 1) / period_of(i))));
                if (m_k[i] == 32 * period_of(i)) begin
                    m_active[i] <= 1'b0;
                    m_done[i]   <= 1'b1;
                    m_valid[i]  <= 1'b1;
                end else begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_active[i]));
                chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(m_done[i]));
                chk($sformatf("sig_valid%0d", i), 32'(valid_w[i]), 32'(m_valid[i]));
                chk($sformatf("signature%0d", i), 32'(sig_w[i]), 32'(m_sig[i]));
                chk($sformatf("match%0d", i), 32'(match_w[i]),
                    32'(m_valid[i] && (m_sig[i] == exp_w[i])));
                if (m_active[i])
                    chk($sformatf("x%0d", i), 32'(x_w[i]), 32'((m_k[i] - 1) / period_of(i)));
            end
        end
    end

    task automatic start_run(input int i);
        @(negedge clk);
        start_w[i] = 1'b1;
        @(negedge clk);
        start_w[i] = 1'b0;
    endtask

    // Called at the negedge of the first busy cycle; lat counts cycles up to and including the done cycle.
    task automatic wait_done(input int i, input int mid, output int lat, output int bc);
        lat = 1;
        bc  = busy_w[i] ? 1 : 0;
        while (!done_w[i] && lat < 400) begin
            start_w[i] = (mid > 0 && lat == mid);
            @(negedge clk);
            lat++;
            if (busy_w[i]) bc++;
        end
        start_w[i] = 1'b0;
        chk($sformatf("done_seen%0d", i), 32'(done_w[i]), 32'd1);
        $display("run on dut%0d mode %0d: latency %0d, busy %0d, signature %05h", i, mode[i], lat, bc, sig_w[i]);
    endtask

    initial begin
        int          lat;
        int          bc;
        int          guard;
        int          done_cnt;
        logic [18:0] golden;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_w[i] = 1'b0;
            mode[i]    = 0;
            exp_w[i]   = 19'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("rst_x%0d", i), 32'(x_w[i]), 32'd0);
            chk($sformatf("rst_sig%0d", i), 32'(sig_w[i]), 32'(SEED_C));
            chk($sformatf("rst_valid%0d", i), 32'(valid_w[i]), 32'd0);
            chk($sformatf("rst_match%0d", i), 32'(match_w[i]), 32'd0);
        end
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Zero response
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("zero_latency", 32'(lat), 32'd33);
        chk("zero_busy_cycles", 32'(bc), 32'd32);
        chk("zero_sig", 32'(sig_w[0]), 32'h0);
        chk("zero_match", 32'(match_w[0]), 32'd1);

        // Only the last or second-to-last pattern responds
        mode[0] = 1;
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("last_only_sig", 32'(sig_w[0]), 32'h00001);
        mode[0] = 2;
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("x30_only_sig", 32'(sig_w[0]), 32'h00002);

        // Netlist golden run, then the f5 fault at x==7
        mode[0]  = 3;
        golden   = misr_run(3);
        exp_w[0] = golden;
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("clean_match", 32'(match_w[0]), 32'd1);
        chk("clean_sig", 32'(sig_w[0]), 32'(golden));
        mode[0] = 4;
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("fault_match", 32'(match_w[0]), 32'd0);
        chk("fault_sig_differs", 32'(sig_w[0] != golden), 32'd1);

        // start during a run is ignored, start in the done cycle restarts
        mode[0] = 3;
        start_run(0);
        wait_done(0, 10, lat, bc);
        chk("busy_start_latency", 32'(lat), 32'd33);
        chk("busy_start_match", 32'(match_w[0]), 32'd1);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        chk("restart_valid_drop", 32'(valid_w[0]), 32'd0);
        chk("restart_busy", 32'(busy_w[0]), 32'd1);
        wait_done(0, 0, lat, bc);
        chk("restart_latency", 32'(lat), 32'd33);

        // Reset at pattern 17
        start_run(0);
        guard = 0;
        while (x_w[0] != 5'd17 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_x17", 32'(x_w[0]), 32'd17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_w[0]), 32'd0);
        chk("midrst_x", 32'(x_w[0]), 32'd0);
        chk("midrst_sig", 32'(sig_w[0]), 32'(SEED_C));
        chk("midrst_done", 32'(done_w[0]), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_w[0]) done_cnt++;
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        start_run(0);
        wait_done(0, 0, lat, bc);
        chk("after_rst_latency", 32'(lat), 32'd33);
        chk("after_rst_busy", 32'(bc), 32'd32);
        chk("after_rst_match", 32'(match_w[0]), 32'd1);

        // SETTLE=2 instance
        mode[1]  = 3;
        exp_w[1] = golden;
        start_run(1);
        wait_done(1, 0, lat, bc);
        chk("settle_latency", 32'(lat), 32'd97);
        chk("settle_busy_cycles", 32'(bc), 32'd96);
        chk("settle_match", 32'(match_w[1]), 32'd1);
        mode[1] = 1;
        start_run(1);
        wait_done(1, 0, lat, bc);
        chk("settle_last_only_sig", 32'(sig_w[1]), 32'h00001);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
